// File: rtl/mips_debug_data_streamer_pkg.sv
// ----------------------------------------------------------------------------
// mips_debug_data_streamer_pkg
// This package is shared by the MicroBlaze-facing debug interface and the
// MIPS-side data streamer. It holds the request-select code map, the frame
// width, and the streamer FSM and frame-source enumerations.
// ----------------------------------------------------------------------------
package mips_debug_data_streamer_pkg;

    localparam int DBG_NB_FRAME  = 32;
    localparam int DBG_NB_SELECT = 6;

    // Any code with a 0 in the MSB selects GPR[code[4:0]].
    localparam logic [5:0] REQ_SEL_MEM_DATA          = 6'b100000;
    localparam logic [5:0] REQ_SEL_MEM_INSTR         = 6'b100001;
    localparam logic [5:0] REQ_SEL_PC                = 6'b100010;
    localparam logic [5:0] REQ_SEL_LATCH_FETCH_DATA  = 6'b100100;
    localparam logic [5:0] REQ_SEL_LATCH_FETCH_CTRL  = 6'b100101;
    localparam logic [5:0] REQ_SEL_LATCH_DECO_DATA   = 6'b100110;
    localparam logic [5:0] REQ_SEL_LATCH_DECO_CTRL   = 6'b100111;
    localparam logic [5:0] REQ_SEL_LATCH_EXEC_DATA   = 6'b101000;
    localparam logic [5:0] REQ_SEL_LATCH_EXEC_CTRL   = 6'b101001;
    localparam logic [5:0] REQ_SEL_LATCH_MEM_DATA    = 6'b101010;
    localparam logic [5:0] REQ_SEL_LATCH_MEM_CTRL    = 6'b101011;
    localparam logic [5:0] REQ_SEL_IDLE              = 6'b111111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_EOD  = 2'd2
    } stream_state_e;

    // Memory reads come back one cycle after the request, so they bypass the
    // snapshot register and are forwarded straight onto the frame bus.
    typedef enum logic [1:0] {
        SRC_SHIFT     = 2'd0,
        SRC_MEM_DATA  = 2'd1,
        SRC_MEM_INSTR = 2'd2
    } frame_src_e;

endpackage

// File: rtl/mips_debug_data_streamer_source_mux.sv
// ----------------------------------------------------------------------------
// debug_source_mux
// This block decodes a request-select code into the snapshot to be
// serialized, the number of frames in it, and the frame source.
//   i_request_select  request code
//   i_reg_read_data   GPR debug read data (already indexed by code[4:0])
//   i_pc              current PC
//   i_latch_*         pipeline latch strips
//   o_snapshot        MSB-aligned snapshot (GPR/PC occupy the top word)
//   o_n_words         frames to send (0 = EOD only)
//   o_src             SRC_SHIFT, or one of the memory pass-through sources
// ----------------------------------------------------------------------------
module debug_source_mux
    import mips_debug_data_streamer_pkg::*;
#(
    parameter int NB_FRAME  = DBG_NB_FRAME,
    parameter int NB_REG    = 32,
    parameter int NB_LATCH  = 96,
    parameter int NB_SELECT = DBG_NB_SELECT,
    parameter int NB_WORDS  = 2
) (
    input  logic [NB_SELECT-1:0] i_request_select,
    input  logic [NB_REG-1:0]    i_reg_read_data,
    input  logic [NB_REG-1:0]    i_pc,
    input  logic [NB_LATCH-1:0]  i_latch_fetch_data,
    input  logic [NB_LATCH-1:0]  i_latch_fetch_ctrl,
    input  logic [NB_LATCH-1:0]  i_latch_deco_data,
    input  logic [NB_LATCH-1:0]  i_latch_deco_ctrl,
    input  logic [NB_LATCH-1:0]  i_latch_exec_data,
    input  logic [NB_LATCH-1:0]  i_latch_exec_ctrl,
    input  logic [NB_LATCH-1:0]  i_latch_mem_data,
    input  logic [NB_LATCH-1:0]  i_latch_mem_ctrl,
    output logic [NB_LATCH-1:0]  o_snapshot,
    output logic [NB_WORDS-1:0]  o_n_words,
    output frame_src_e           o_src
);

    localparam int N_LATCH_WORDS = NB_LATCH / NB_FRAME;

    always_comb begin
        o_snapshot = '0;
        o_n_words  = '0;
        o_src      = SRC_SHIFT;
        casez (i_request_select)
            6'b0?????: begin
                o_snapshot = NB_LATCH'(i_reg_read_data) << (NB_LATCH - NB_REG);
                o_n_words  = NB_WORDS'(1);
            end
            REQ_SEL_MEM_DATA: begin
                o_n_words = NB_WORDS'(1);
                o_src     = SRC_MEM_DATA;
            end
            REQ_SEL_MEM_INSTR: begin
                o_n_words = NB_WORDS'(1);
                o_src     = SRC_MEM_INSTR;
            end
            REQ_SEL_PC: begin
                o_snapshot = NB_LATCH'(i_pc) << (NB_LATCH - NB_REG);
                o_n_words  = NB_WORDS'(1);
            end
            REQ_SEL_LATCH_FETCH_DATA: begin
                o_snapshot = i_latch_fetch_data;
                o_n_words  = NB_WORDS'(N_LATCH_WORDS);
            end
            REQ_SEL_LATCH_FETCH_CTRL: begin
                o_snapshot = i_latch_fetch_ctrl;
                o_n_words  = NB_WORDS'(N_LATCH_WORDS);
            end
            REQ_SEL_LATCH_DECO_DATA: begin
                o_snapshot = i_latch_deco_data;
                o_n_words  = NB_WORDS'(N_LATCH_WORDS);
            end
            REQ_SEL_LATCH_DECO_CTRL: begin
                o_snapshot = i_latch_deco_ctrl;
                o_n_words  = NB_WORDS'(N_LATCH_WORDS);
            end
            REQ_SEL_LATCH_EXEC_DATA: begin
                o_snapshot = i_latch_exec_data;
                o_n_words  = NB_WORDS'(N_LATCH_WORDS);
            end
            REQ_SEL_LATCH_EXEC_CTRL: begin
                o_snapshot = i_latch_exec_ctrl;
                o_n_words  = NB_WORDS'(N_LATCH_WORDS);
            end
            REQ_SEL_LATCH_MEM_DATA: begin
                o_snapshot = i_latch_mem_data;
                o_n_words  = NB_WORDS'(N_LATCH_WORDS);
            end
            REQ_SEL_LATCH_MEM_CTRL: begin
                o_snapshot = i_latch_mem_ctrl;
                o_n_words  = NB_WORDS'(N_LATCH_WORDS);
            end
            default: begin
                // Undefined codes (and idle) carry no data: EOD only.
                o_n_words = '0;
            end
        endcase
    end

endmodule

// File: rtl/mips_debug_data_streamer.sv
// ----------------------------------------------------------------------------
// mips_debug_data_streamer
// This is the MIPS-side responder for the debug request channel. It
// snapshots the selected source, streams it MSB word first, one frame per
// cycle, and then emits a single EOD pulse.
//   i_clock / i_reset        clock, synchronous active-high reset
//   i_request_select         one-cycle request code (all ones = none)
//   o_reg_read_addr          GPR debug read index (combinational)
//   i_reg_read_data          GPR debug read data
//   i_pc                     current PC
//   i_mem_data/i_instr_data  memory read data, valid the cycle after request
//   i_latch_*                pipeline latch strips
//   o_frame_to_interface     serialized frame (0 outside SEND)
//   o_eod                    end-of-data pulse
//   o_busy                   transfer in progress
// ----------------------------------------------------------------------------
module mips_debug_data_streamer
    import mips_debug_data_streamer_pkg::*;
#(
    parameter int NB_FRAME    = DBG_NB_FRAME,
    parameter int NB_REG      = 32,
    parameter int NB_LATCH    = 96,
    parameter int NB_SELECT   = DBG_NB_SELECT,
    parameter int NB_REG_ADDR = 5
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [NB_SELECT-1:0]   i_request_select,
    output logic [NB_REG_ADDR-1:0] o_reg_read_addr,
    input  logic [NB_REG-1:0]      i_reg_read_data,
    input  logic [NB_REG-1:0]      i_pc,
    input  logic [NB_REG-1:0]      i_mem_data,
    input  logic [NB_REG-1:0]      i_instr_data,
    input  logic [NB_LATCH-1:0]    i_latch_fetch_data,
    input  logic [NB_LATCH-1:0]    i_latch_fetch_ctrl,
    input  logic [NB_LATCH-1:0]    i_latch_deco_data,
    input  logic [NB_LATCH-1:0]    i_latch_deco_ctrl,
    input  logic [NB_LATCH-1:0]    i_latch_exec_data,
    input  logic [NB_LATCH-1:0]    i_latch_exec_ctrl,
    input  logic [NB_LATCH-1:0]    i_latch_mem_data,
    input  logic [NB_LATCH-1:0]    i_latch_mem_ctrl,
    output logic [NB_FRAME-1:0]    o_frame_to_interface,
    output logic                   o_eod,
    output logic                   o_busy
);

    localparam int N_LATCH_WORDS = NB_LATCH / NB_FRAME;
    localparam int NB_WORDS      = $clog2(N_LATCH_WORDS + 1);

    stream_state_e         state_q, state_d;
    frame_src_e            src_q, src_d;
    logic [NB_LATCH-1:0]   shift_q, shift_d;
    logic [NB_WORDS-1:0]   words_left_q, words_left_d;
    logic                  eod_q, eod_d;

    logic [NB_LATCH-1:0]   mux_snapshot;
    logic [NB_WORDS-1:0]   mux_n_words;
    frame_src_e            mux_src;

    assign o_reg_read_addr = i_request_select[NB_REG_ADDR-1:0];

    debug_source_mux #(
        .NB_FRAME  (NB_FRAME),
        .NB_REG    (NB_REG),
        .NB_LATCH  (NB_LATCH),
        .NB_SELECT (NB_SELECT),
        .NB_WORDS  (NB_WORDS)
    ) u_source_mux (
        .i_request_select   (i_request_select),
        .i_reg_read_data    (i_reg_read_data),
        .i_pc               (i_pc),
        .i_latch_fetch_data (i_latch_fetch_data),
        .i_latch_fetch_ctrl (i_latch_fetch_ctrl),
        .i_latch_deco_data  (i_latch_deco_data),
        .i_latch_deco_ctrl  (i_latch_deco_ctrl),
        .i_latch_exec_data  (i_latch_exec_data),
        .i_latch_exec_ctrl  (i_latch_exec_ctrl),
        .i_latch_mem_data   (i_latch_mem_data),
        .i_latch_mem_ctrl   (i_latch_mem_ctrl),
        .o_snapshot         (mux_snapshot),
        .o_n_words          (mux_n_words),
        .o_src              (mux_src)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            src_q        <= SRC_SHIFT;
            shift_q      <= '0;
            words_left_q <= '0;
            eod_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            shift_q      <= shift_d;
            words_left_q <= words_left_d;
            eod_q        <= eod_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        shift_d      = shift_q;
        words_left_d = words_left_q;
        eod_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_request_select != NB_SELECT'(REQ_SEL_IDLE)) begin
                    shift_d = mux_snapshot;
                    src_d   = mux_src;
                    if (mux_n_words == '0) begin
                        state_d = ST_EOD;
                        eod_d   = 1'b1;
                    end else begin
                        words_left_d = mux_n_words - NB_WORDS'(1);
                        state_d      = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                shift_d = shift_q << NB_FRAME;
                if (words_left_q == '0) begin
                    state_d = ST_EOD;
                    eod_d   = 1'b1;
                end else begin
                    words_left_d = words_left_q - NB_WORDS'(1);
                end
            end
            ST_EOD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The frame is gated by the registered state and taken from the
    // snapshot register. Memory reads arrive one cycle after the request,
    // so they are forwarded straight through during their single SEND cycle.
    always_comb begin
        o_frame_to_interface = '0;
        if (state_q == ST_SEND) begin
            case (src_q)
                SRC_MEM_DATA:  o_frame_to_interface = i_mem_data;
                SRC_MEM_INSTR: o_frame_to_interface = i_instr_data;
                default:       o_frame_to_interface = shift_q[NB_LATCH-1 -: NB_FRAME];
            endcase
        end
    end

    assign o_eod  = eod_q;
    assign o_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mips_debug_data_streamer.sv
module tb_mips_debug_data_streamer;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic [5:0]  i_request_select;
    logic [4:0]  o_reg_read_addr;
    logic [31:0] i_reg_read_data;
    logic [31:0] i_pc;
    logic [31:0] i_mem_data;
    logic [31:0] i_instr_data;
    logic [95:0] strip [8];
    logic [31:0] o_frame_to_interface;
    logic        o_eod;
    logic        o_busy;

    logic [31:0] gpr [32];

    int checks = 0;
    int errors = 0;

    always #5 i_clock = ~i_clock;

    assign i_reg_read_data = gpr[o_reg_read_addr];

    mips_debug_data_streamer dut (
        .i_clock              (i_clock),
        .i_reset              (i_reset),
        .i_request_select     (i_request_select),
        .o_reg_read_addr      (o_reg_read_addr),
        .i_reg_read_data      (i_reg_read_data),
        .i_pc                 (i_pc),
        .i_mem_data           (i_mem_data),
        .i_instr_data         (i_instr_data),
        .i_latch_fetch_data   (strip[0]),
        .i_latch_fetch_ctrl   (strip[1]),
        .i_latch_deco_data    (strip[2]),
        .i_latch_deco_ctrl    (strip[3]),
        .i_latch_exec_data    (strip[4]),
        .i_latch_exec_ctrl    (strip[5]),
        .i_latch_mem_data     (strip[6]),
        .i_latch_mem_ctrl     (strip[7]),
        .o_frame_to_interface (o_frame_to_interface),
        .o_eod                (o_eod),
        .o_busy               (o_busy)
    );

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        tick();
        tick();
        checks++;
        if (o_frame_to_interface !== 32'h0) begin
            errors++; $display("FAIL reset_frame: got %h want %h", o_frame_to_interface, 32'h0);
        end
        checks++;
        if (o_eod !== 1'b0) begin
            errors++; $display("FAIL reset_eod: got %b want 0", o_eod);
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b want 0", o_busy);
        end
        i_reset = 1'b0;
        tick();
    endtask

    task automatic test_gpr();
        gpr[5] = 32'hDEADBEEF;
        i_request_select = 6'b000101;
        #1;
        checks++;
        if (o_reg_read_addr !== 5'd5) begin
            errors++; $display("FAIL gpr_addr: got %0d want 5", o_reg_read_addr);
        end
        tick();                                  // T+1
        i_request_select = 6'h3F;
        gpr[5] = 32'h0;                          // snapshot must already be held
        #1;
        checks++;
        if (o_frame_to_interface !== 32'hDEADBEEF) begin
            errors++; $display("FAIL gpr_word: got %h want %h", o_frame_to_interface, 32'hDEADBEEF);
        end
        checks++;
        if (o_busy !== 1'b1 || o_eod !== 1'b0) begin
            errors++; $display("FAIL gpr_busy_t1: got busy=%b eod=%b want busy=1 eod=0", o_busy, o_eod);
        end
        tick();                                  // T+2
        checks++;
        if (o_eod !== 1'b1 || o_busy !== 1'b1 || o_frame_to_interface !== 32'h0) begin
            errors++; $display("FAIL gpr_eod: got eod=%b busy=%b frame=%h want eod=1 busy=1 frame=0",
                               o_eod, o_busy, o_frame_to_interface);
        end
        tick();                                  // T+3
        checks++;
        if (o_eod !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL gpr_done: got eod=%b busy=%b want 0 0", o_eod, o_busy);
        end
    endtask

    task automatic test_latch_fetch();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h11111111;
        exp_w[1] = 32'h22222222;
        exp_w[2] = 32'h33333333;
        strip[0] = 96'h111111112222222233333333;
        i_request_select = 6'b100100;
        for (int k = 0; k < 3; k++) begin
            tick();                              // T+1+k
            i_request_select = 6'h3F;
            if (k == 1) strip[0] = 96'hFFFFFFFF_FFFFFFFF_FFFFFFFF;
            #1;
            checks++;
            if (o_frame_to_interface !== exp_w[k] || o_eod !== 1'b0) begin
                errors++; $display("FAIL latch_word%0d: got %h eod=%b want %h eod=0",
                                   k, o_frame_to_interface, o_eod, exp_w[k]);
            end
        end
        tick();                                  // T+4
        checks++;
        if (o_eod !== 1'b1 || o_frame_to_interface !== 32'h0) begin
            errors++; $display("FAIL latch_eod: got eod=%b frame=%h want eod=1 frame=0",
                               o_eod, o_frame_to_interface);
        end
        tick();
    endtask

    task automatic test_latch_order();
        logic [31:0] top [8];
        top[0] = 32'hA0A0A0A0; top[1] = 32'hA1A1A1A1;
        top[2] = 32'hA2A2A2A2; top[3] = 32'hA3A3A3A3;
        top[4] = 32'hA4A4A4A4; top[5] = 32'hA5A5A5A5;
        top[6] = 32'hA6A6A6A6; top[7] = 32'hA7A7A7A7;
        for (int i = 0; i < 8; i++) strip[i] = {top[i], 32'h00000055, 32'h000000AA};
        for (int i = 0; i < 8; i++) begin
            i_request_select = 6'h24 + 6'(i);
            tick();                              // T+1
            i_request_select = 6'h3F;
            #1;
            checks++;
            if (o_frame_to_interface !== top[i]) begin
                errors++; $display("FAIL latch_sel_%0d_w0: got %h want %h", i, o_frame_to_interface, top[i]);
            end
            tick();                              // T+2
            tick();                              // T+3
            checks++;
            if (o_frame_to_interface !== 32'h000000AA) begin
                errors++; $display("FAIL latch_sel_%0d_w2: got %h want %h", i, o_frame_to_interface, 32'h000000AA);
            end
            tick();                              // T+4
            checks++;
            if (o_eod !== 1'b1) begin
                errors++; $display("FAIL latch_sel_%0d_eod: got %b want 1", i, o_eod);
            end
            tick();
        end
    endtask

    task automatic test_mem();
        i_request_select = 6'b100000;
        tick();                                  // T+1
        i_request_select = 6'h3F;
        i_mem_data   = 32'hCAFEF00D;
        i_instr_data = 32'h12345678;
        #1;
        checks++;
        if (o_frame_to_interface !== 32'hCAFEF00D) begin
            errors++; $display("FAIL mem_data: got %h want %h", o_frame_to_interface, 32'hCAFEF00D);
        end
        tick();                                  // T+2
        checks++;
        if (o_eod !== 1'b1 || o_frame_to_interface !== 32'h0) begin
            errors++; $display("FAIL mem_data_eod: got eod=%b frame=%h want eod=1 frame=0",
                               o_eod, o_frame_to_interface);
        end
        tick();
        i_request_select = 6'b100001;
        tick();                                  // T+1
        i_request_select = 6'h3F;
        i_instr_data = 32'h0BADC0DE;
        #1;
        checks++;
        if (o_frame_to_interface !== 32'h0BADC0DE) begin
            errors++; $display("FAIL mem_instr: got %h want %h", o_frame_to_interface, 32'h0BADC0DE);
        end
        tick();
        checks++;
        if (o_eod !== 1'b1) begin
            errors++; $display("FAIL mem_instr_eod: got %b want 1", o_eod);
        end
        tick();
    endtask

    task automatic test_undefined();
        logic [5:0] codes [3];
        codes[0] = 6'b100011;
        codes[1] = 6'b101100;
        codes[2] = 6'b111110;
        for (int i = 0; i < 3; i++) begin
            i_request_select = codes[i];
            tick();                              // T+1
            i_request_select = 6'h3F;
            #1;
            checks++;
            if (o_eod !== 1'b1 || o_frame_to_interface !== 32'h0 || o_busy !== 1'b1) begin
                errors++; $display("FAIL undef_%0d: got eod=%b frame=%h busy=%b want eod=1 frame=0 busy=1",
                                   i, o_eod, o_frame_to_interface, o_busy);
            end
            tick();                              // T+2
            checks++;
            if (o_eod !== 1'b0 || o_busy !== 1'b0) begin
                errors++; $display("FAIL undef_%0d_after: got eod=%b busy=%b want 0 0", i, o_eod, o_busy);
            end
        end
    endtask

    task automatic test_idle();
        i_request_select = 6'h3F;
        tick();
        tick();
        checks++;
        if (o_busy !== 1'b0 || o_eod !== 1'b0 || o_frame_to_interface !== 32'h0) begin
            errors++; $display("FAIL idle: got busy=%b eod=%b frame=%h want 0 0 0",
                               o_busy, o_eod, o_frame_to_interface);
        end
    endtask

    task automatic test_back_to_back();
        strip[7] = 96'h7777777788888888_99999999;
        i_pc = 32'h00400010;
        i_request_select = 6'b101011;            // T
        tick();                                  // T+1
        i_request_select = 6'h3F;
        #1;
        checks++;
        if (o_frame_to_interface !== 32'h77777777) begin
            errors++; $display("FAIL b2b_w0: got %h want %h", o_frame_to_interface, 32'h77777777);
        end
        tick();                                  // T+2: request while busy
        i_request_select = 6'b100010;
        tick();                                  // T+3
        i_request_select = 6'h3F;
        #1;
        checks++;
        if (o_frame_to_interface !== 32'h99999999) begin
            errors++; $display("FAIL b2b_w2: got %h want %h", o_frame_to_interface, 32'h99999999);
        end
        tick();                                  // T+4
        checks++;
        if (o_eod !== 1'b1) begin
            errors++; $display("FAIL b2b_eod: got %b want 1", o_eod);
        end
        tick();                                  // T+5
        checks++;
        if (o_busy !== 1'b0 || o_eod !== 1'b0) begin
            errors++; $display("FAIL b2b_ignored: got busy=%b eod=%b want 0 0", o_busy, o_eod);
        end
        i_request_select = 6'b100010;
        tick();                                  // T+6
        i_request_select = 6'h3F;
        #1;
        checks++;
        if (o_frame_to_interface !== 32'h00400010) begin
            errors++; $display("FAIL b2b_pc: got %h want %h", o_frame_to_interface, 32'h00400010);
        end
        tick();
        checks++;
        if (o_eod !== 1'b1) begin
            errors++; $display("FAIL b2b_pc_eod: got %b want 1", o_eod);
        end
        tick();
    endtask

    task automatic test_reset_mid_transfer();
        strip[2] = 96'h44444444_55555555_66666666;
        i_pc = 32'h00400020;
        i_request_select = 6'b100110;            // T
        tick();                                  // T+1
        i_request_select = 6'h3F;
        tick();                                  // T+2
        i_reset = 1'b1;
        tick();                                  // T+3
        checks++;
        if (o_frame_to_interface !== 32'h0 || o_eod !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid: got frame=%h eod=%b busy=%b want 0 0 0",
                               o_frame_to_interface, o_eod, o_busy);
        end
        i_reset = 1'b0;
        tick();                                  // T+4
        checks++;
        if (o_eod !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_no_eod: got eod=%b busy=%b want 0 0", o_eod, o_busy);
        end
        i_request_select = 6'b100010;
        tick();                                  // T+5
        i_request_select = 6'h3F;
        #1;
        checks++;
        if (o_frame_to_interface !== 32'h00400020) begin
            errors++; $display("FAIL rst_mid_pc: got %h want %h", o_frame_to_interface, 32'h00400020);
        end
        tick();
        checks++;
        if (o_eod !== 1'b1) begin
            errors++; $display("FAIL rst_mid_pc_eod: got %b want 1", o_eod);
        end
        tick();
    endtask

    initial begin
        i_reset          = 1'b1;
        i_request_select = 6'h3F;
        i_pc             = 32'h0;
        i_mem_data       = 32'h0;
        i_instr_data     = 32'h0;
        for (int i = 0; i < 8; i++)  strip[i] = '0;
        for (int i = 0; i < 32; i++) gpr[i] = 32'h0;

        test_reset();
        test_gpr();
        test_latch_fetch();
        test_latch_order();
        test_mem();
        test_undefined();
        test_idle();
        test_back_to_back();
        test_reset_mid_transfer();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
